// File: rtl/dcp_run_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : dcp_run_ctrl_if                                           |
// | Brief  : Command/CPU-control bundle between debug decoder and DCP. |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
interface dcp_run_ctrl_if #(
    parameter int NUM_BP = 4
);
    logic              start;
    logic [2:0]        op;
    logic [31:0]       arg;
    logic              abort;
    logic [31:0]       PC;
    logic              cpu_en;
    logic              busy;
    logic              done;
    logic [1:0]        status;
    logic [NUM_BP-1:0] bp_valid;

    modport master (
        output start, op, arg, abort, PC,
        input  cpu_en, busy, done, status, bp_valid
    );

    modport slave (
        input  start, op, arg, abort, PC,
        output cpu_en, busy, done, status, bp_valid
    );
endinterface
`default_nettype wire

// File: rtl/dcp_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : dcp_run_ctrl                                              |
// | Brief  : Debug run control: single-step, free-run with PC          |
// |          breakpoints, abort and timeout, breakpoint table upkeep.  |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module dcp_run_ctrl #(
    parameter int          NUM_BP  = 4,
    parameter logic [31:0] TIMEOUT = 32'd1_000_000
) (
    input  wire logic         clk,
    input  wire logic         rst,
    dcp_run_ctrl_if.slave     bus
);
    localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

    localparam logic [2:0] c_op_step   = 3'd0;
    localparam logic [2:0] c_op_go     = 3'd1;
    localparam logic [2:0] c_op_setbp  = 3'd2;
    localparam logic [2:0] c_op_clrbp  = 3'd3;
    localparam logic [2:0] c_op_clrall = 3'd4;

    localparam logic [1:0] c_st_ok    = 2'd0;
    localparam logic [1:0] c_st_bp    = 2'd1;
    localparam logic [1:0] c_st_abort = 2'd2;
    localparam logic [1:0] c_st_err   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_first;
    logic [31:0]       r_cnt;
    logic [1:0]        r_status;
    logic [1:0]        w_status_nxt;
    logic [NUM_BP-1:0] r_bp_valid;
    logic [NUM_BP-1:0] w_bp_valid_nxt;
    logic [31:0]       r_bp_addr [NUM_BP];

    logic              w_hit;
    logic [NUM_BP-1:0] w_arg_match;
    logic              w_free_found;
    logic [IDX_W-1:0]  w_free_idx;
    logic              w_wr_en;
    logic              w_cpu_en;
    logic              w_go_accept;
    logic              w_timeout;

    always_comb begin
        w_hit        = 1'b0;
        w_arg_match  = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (r_bp_valid[i] && (r_bp_addr[i] == bus.PC)) begin
                w_hit = 1'b1;
            end
            w_arg_match[i] = r_bp_valid[i] && (r_bp_addr[i] == bus.arg);
        end
        // Walk downward so the last assignment is the lowest free index.
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (!r_bp_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    assign w_timeout   = (r_cnt >= TIMEOUT);
    assign w_go_accept = (r_state == S_IDLE) && bus.start && (bus.op == c_op_go);

    always_comb begin
        w_next         = r_state;
        w_cpu_en       = 1'b0;
        w_status_nxt   = r_status;
        w_bp_valid_nxt = r_bp_valid;
        w_wr_en        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = S_DONE;
                    case (bus.op)
                        c_op_step: w_next = S_STEP;
                        c_op_go:   w_next = S_RUN;
                        c_op_setbp: begin
                            if (|w_arg_match) begin
                                w_status_nxt = c_st_ok;
                            end else if (w_free_found) begin
                                w_wr_en                    = 1'b1;
                                w_bp_valid_nxt[w_free_idx] = 1'b1;
                                w_status_nxt               = c_st_ok;
                            end else begin
                                w_status_nxt = c_st_err;
                            end
                        end
                        c_op_clrbp: begin
                            w_bp_valid_nxt = r_bp_valid & ~w_arg_match;
                            w_status_nxt   = c_st_ok;
                        end
                        c_op_clrall: begin
                            w_bp_valid_nxt = '0;
                            w_status_nxt   = c_st_ok;
                        end
                        default: w_status_nxt = c_st_err;
                    endcase
                end
            end
            S_STEP: begin
                w_next = S_DONE;
                if (bus.abort) begin
                    w_status_nxt = c_st_abort;
                end else begin
                    w_cpu_en     = 1'b1;
                    w_status_nxt = c_st_ok;
                end
            end
            S_RUN: begin
                // First cycle always executes so GO can resume from a breakpoint.
                if (r_first) begin
                    w_cpu_en = 1'b1;
                end else if (bus.abort) begin
                    w_next       = S_DONE;
                    w_status_nxt = c_st_abort;
                end else if (w_hit) begin
                    w_next       = S_DONE;
                    w_status_nxt = c_st_bp;
                end else if (w_timeout) begin
                    w_next       = S_DONE;
                    w_status_nxt = c_st_abort;
                end else begin
                    w_cpu_en = 1'b1;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_first    <= 1'b0;
            r_cnt      <= '0;
            r_status   <= c_st_ok;
            r_bp_valid <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                r_bp_addr[i] <= '0;
            end
        end else begin
            r_state    <= w_next;
            r_first    <= w_go_accept;
            r_status   <= w_status_nxt;
            r_bp_valid <= w_bp_valid_nxt;
            if (w_go_accept) begin
                r_cnt <= '0;
            end else if ((r_state == S_RUN) && w_cpu_en) begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (w_wr_en) begin
                r_bp_addr[w_free_idx] <= bus.arg;
            end
        end
    end

    assign bus.cpu_en   = w_cpu_en;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.status   = r_status;
    assign bus.bp_valid = r_bp_valid;

endmodule
`default_nettype wire

// File: tb/tb_dcp_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_dcp_run_ctrl                                           |
// | Brief  : Directed vector bench for dcp_run_ctrl (NUM_BP=4,         |
// |          TIMEOUT=8) with a simple PC-advancing CPU model.          |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_dcp_run_ctrl;
    localparam logic [2:0] OP_STEP   = 3'd0;
    localparam logic [2:0] OP_GO     = 3'd1;
    localparam logic [2:0] OP_SETBP  = 3'd2;
    localparam logic [2:0] OP_CLRBP  = 3'd3;
    localparam logic [2:0] OP_CLRALL = 3'd4;

    logic clk;
    logic rst;
    logic pc_set;
    logic [31:0] pc_set_val;
    int total;
    int bad;

    dcp_run_ctrl_if #(.NUM_BP(4)) bus ();

    dcp_run_ctrl #(
        .NUM_BP  (4),
        .TIMEOUT (32'd8)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CPU model: one instruction (PC += 4) per enabled cycle.
    always @(posedge clk) begin
        if (pc_set)
            bus.PC <= pc_set_val;
        else if (bus.cpu_en)
            bus.PC <= bus.PC + 32'd4;
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] arg;
        int          abort_at;
        logic [1:0]  st;
        logic [3:0]  bpv;
        int          n_en;
        int          n_busy;
    } vec_t;

    vec_t vt [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_pc(input logic [31:0] v);
        @(negedge clk);
        pc_set     = 1'b1;
        pc_set_val = v;
        @(negedge clk);
        pc_set     = 1'b0;
    endtask

    task automatic run_cmd(input logic [2:0] o, input logic [31:0] a,
                           input int abort_at, input int inj_at,
                           output int n_en, output int n_busy, output bit first_en,
                           output bit got, output logic [1:0] st);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.arg   = a;
        n_en = 0; n_busy = 0; first_en = 1'b0; got = 1'b0; st = 2'd0;
        cyc = 1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            bus.start = (inj_at == cyc);
            if (inj_at == cyc) begin
                bus.op  = OP_SETBP;
                bus.arg = 32'h999;
            end
            bus.abort = (abort_at != 0) && (cyc >= abort_at);
            #1;
            if (cyc == 1) first_en = bus.cpu_en;
            n_en   += int'(bus.cpu_en);
            n_busy += int'(bus.busy);
            if (bus.done) begin
                got = 1'b1;
                st  = bus.status;
            end
            cyc++;
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        int n_en, n_busy, done_cnt;
        bit first_en, got;
        logic [1:0] st;

        total = 0; bad = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 3'd0; bus.arg = 32'd0; bus.abort = 1'b0;
        pc_set = 1'b1; pc_set_val = 32'd0;

        //           op          arg     ab  st    bpv      en busy
        vt[0]  = '{OP_CLRALL, 32'h0,   0, 2'd0, 4'b0000, 0, 1};
        vt[1]  = '{OP_STEP,   32'h0,   0, 2'd0, 4'b0000, 1, 2};
        vt[2]  = '{OP_STEP,   32'h0,   1, 2'd2, 4'b0000, 0, 2};
        vt[3]  = '{OP_SETBP,  32'h100, 0, 2'd0, 4'b0001, 0, 1};
        vt[4]  = '{OP_SETBP,  32'h200, 0, 2'd0, 4'b0011, 0, 1};
        vt[5]  = '{OP_SETBP,  32'h300, 0, 2'd0, 4'b0111, 0, 1};
        vt[6]  = '{OP_SETBP,  32'h400, 0, 2'd0, 4'b1111, 0, 1};
        vt[7]  = '{OP_SETBP,  32'h500, 0, 2'd3, 4'b1111, 0, 1};
        vt[8]  = '{OP_SETBP,  32'h100, 0, 2'd0, 4'b1111, 0, 1};
        vt[9]  = '{OP_CLRBP,  32'h200, 0, 2'd0, 4'b1101, 0, 1};
        vt[10] = '{OP_CLRBP,  32'h200, 0, 2'd0, 4'b1101, 0, 1};
        vt[11] = '{OP_SETBP,  32'h500, 0, 2'd0, 4'b1111, 0, 1};
        vt[12] = '{OP_CLRBP,  32'h500, 0, 2'd0, 4'b1101, 0, 1};
        vt[13] = '{3'd6,      32'h0,   0, 2'd3, 4'b1101, 0, 1};
        vt[14] = '{3'd7,      32'h0,   0, 2'd3, 4'b1101, 0, 1};
        vt[15] = '{OP_CLRALL, 32'h0,   0, 2'd0, 4'b0000, 0, 1};
        vt[16] = '{OP_SETBP,  32'h10,  0, 2'd0, 4'b0001, 0, 1};

        repeat (3) @(negedge clk);
        check("rst_cpu_en",   32'(bus.cpu_en),   32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_done",     32'(bus.done),     32'd0);
        check("rst_status",   32'(bus.status),   32'd0);
        check("rst_bp_valid", 32'(bus.bp_valid), 32'd0);
        rst = 1'b0;
        pc_set = 1'b0;

        for (int i = 0; i < 17; i++) begin
            run_cmd(vt[i].op, vt[i].arg, vt[i].abort_at, 0, n_en, n_busy, first_en, got, st);
            check($sformatf("vec%0d_done", i),   32'(got), 32'd1);
            check($sformatf("vec%0d_status", i), 32'(st), 32'(vt[i].st));
            check($sformatf("vec%0d_bpv", i),    32'(bus.bp_valid), 32'(vt[i].bpv));
            check($sformatf("vec%0d_en", i),     32'(n_en), 32'(vt[i].n_en));
            check($sformatf("vec%0d_busy", i),   32'(n_busy), 32'(vt[i].n_busy));
        end

        // Breakpoint at 0x10, run from 0x0
        set_pc(32'h0);
        run_cmd(OP_GO, 32'h0, 0, 0, n_en, n_busy, first_en, got, st);
        check("go_bp_done",   32'(got), 32'd1);
        check("go_bp_status", 32'(st), 32'd1);
        check("go_bp_en",     32'(n_en), 32'd4);
        check("go_bp_pc",     bus.PC, 32'h10);
        check("status_hold",  32'(bus.status), 32'd1);

        // Resume from the breakpoint address, then run into the timeout
        run_cmd(OP_GO, 32'h0, 0, 0, n_en, n_busy, first_en, got, st);
        check("resume_first_en", 32'(first_en), 32'd1);
        check("resume_status",   32'(st), 32'd2);
        check("resume_en",       32'(n_en), 32'd8);
        check("resume_pc",       bus.PC, 32'h30);

        // SETBP strobe while running is ignored
        run_cmd(OP_GO, 32'h0, 0, 2, n_en, n_busy, first_en, got, st);
        check("inj_done",   32'(got), 32'd1);
        check("inj_status", 32'(st), 32'd2);
        check("inj_bpv",    32'(bus.bp_valid), 32'd1);

        // Abort on third RUN cycle
        run_cmd(OP_CLRALL, 32'h0, 0, 0, n_en, n_busy, first_en, got, st);
        run_cmd(OP_GO, 32'h0, 3, 0, n_en, n_busy, first_en, got, st);
        check("abort_done",   32'(got), 32'd1);
        check("abort_status", 32'(st), 32'd2);
        check("abort_en",     32'(n_en), 32'd2);

        // Async reset mid-run
        run_cmd(OP_SETBP, 32'h5000, 0, 0, n_en, n_busy, first_en, got, st);
        set_pc(32'h100);
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_GO;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_rst_cpu_en", 32'(bus.cpu_en), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_cpu_en",   32'(bus.cpu_en),   32'd0);
        check("mid_rst_busy",     32'(bus.busy),     32'd0);
        check("mid_rst_bp_valid", 32'(bus.bp_valid), 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 4) rst = 1'b0;
            #1;
            done_cnt += int'(bus.done);
        end
        check("mid_rst_no_done", 32'(done_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dcp_run_ctrl.md
DCP_RUN_CTRL -- requirements
Module: dcp_run_ctrl

Interface
REQ-001 Parameter NUM_BP, default 4; number of PC breakpoint slots (1..8).
REQ-002 Parameter TIMEOUT, default 32'd1_000_000; maximum cpu_en cycles per GO before forced stop.
REQ-003 clk  input  1  single system clock; all state on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle command strobe from the debug command decoder.
REQ-006 op  input  3  command: 0 STEP, 1 GO, 2 SETBP, 3 CLRBP, 4 CLRALL, 5-7 invalid.
REQ-007 arg  input  32  breakpoint address for SETBP/CLRBP; ignored otherwise.
REQ-008 abort  input  1  level request to stop a STEP/GO in progress.
REQ-009 PC  input  32  current CPU program counter (address of next instruction to execute).
REQ-010 cpu_en  output  1  CPU clock enable; CPU retires exactly one instruction per clk cycle with cpu_en=1.
REQ-011 busy  output  1  high while a command is in progress.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 status  output  2  valid with done, held until next done: 0 OK, 1 breakpoint hit, 2 abort/timeout, 3 error.
REQ-014 bp_valid  output  NUM_BP  per-slot valid bits, for display by the debug command processor.

Function
REQ-015 FSM states IDLE, STEP, RUN, DONE; busy=1 in STEP, RUN, DONE.
REQ-016 start is sampled only in IDLE; start in any other state SHALL be ignored with no side effect.
REQ-017 IDLE+start, op=STEP -> STEP; STEP lasts one cycle with cpu_en=1, then DONE, status 0.
REQ-018 IDLE+start, op=GO -> RUN; run counter cleared; first RUN cycle cpu_en=1 unconditionally (resume from a breakpoint address).
REQ-019 Subsequent RUN cycles: hit = any slot i with bp_valid[i] and bp_addr[i]==PC; cpu_en = !hit && !abort (combinational, same cycle).
REQ-020 RUN exit priority: abort -> DONE status 2; else hit -> DONE status 1; else counter reaches TIMEOUT -> DONE status 2; stopping cycle has cpu_en=0.
REQ-021 Run counter is 32 bits, increments on each cpu_en=1 cycle in RUN, never wraps (TIMEOUT check precedes overflow).
REQ-022 abort in STEP: cpu_en=0 that cycle, DONE status 2; abort in IDLE ignored.
REQ-023 SETBP: IDLE -> DONE in one cycle; if arg already in a valid slot, no change, status 0; else write lowest-index free slot, status 0; if all slots valid, no change, status 3.
REQ-024 CLRBP: invalidate every valid slot whose address equals arg; status 0 whether or not found.
REQ-025 CLRALL: bp_valid cleared to all-zero; status 0.
REQ-026 Invalid op (5-7): IDLE -> DONE, status 3, no other effect.
REQ-027 DONE lasts one cycle: done=1, cpu_en=0, then IDLE; earliest next start accepted the cycle after done.
REQ-028 Breakpoint table changes only through SETBP/CLRBP/CLRALL; bp_addr compare uses full 32 bits.
REQ-029 cpu_en SHALL be 0 in IDLE and DONE; total cpu_en cycles per STEP is exactly 1.

Reset
REQ-030 rst=1 asynchronously forces: state IDLE, cpu_en=0, busy=0, done=0, status=0, bp_valid=0, all bp_addr=0, run counter=0.
REQ-031 rst asserted mid-RUN stops cpu_en in the same cycle (async) and produces no done pulse.

Verification
REQ-032 Reset, STEP -> cpu_en=1 for exactly one cycle, done next cycle, status=0, busy 2 cycles.
REQ-033 SETBP 0x10, PC increments by 4 from 0x0, GO -> 4 cpu_en cycles (PC 0x0-0xC), cpu_en=0 when PC=0x10, done status=1; GO again at PC=0x10 -> first cycle cpu_en=1 (resume).
REQ-034 SETBP 5 distinct addresses with NUM_BP=4 -> first four status 0, fifth status 3, bp_valid=4'b1111; CLRBP second address -> bp_valid=4'b1101; repeat SETBP -> fills slot 1.
REQ-035 TIMEOUT=8, GO with no breakpoints -> exactly 8 cpu_en cycles, done status=2; abort raised on 3rd RUN cycle instead -> 2 cpu_en cycles, status=2.
REQ-036 start pulsed during RUN with op=SETBP -> ignored, bp_valid unchanged; op=6 in IDLE -> done status=3.
REQ-037 rst asserted mid-RUN between clock edges -> cpu_en, busy, bp_valid drop immediately, no done pulse.
